// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared CPU constants and types used by the fetch PC controller.
// Holds the machine width, fetch block geometry and default reset vector.
package fetch_pc_ctrl_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned FETCH_BYTES   = 16;
  localparam int unsigned FETCH_WORDS   = FETCH_BYTES / 4;
  localparam int unsigned WORD_IDX_W    = $clog2(FETCH_WORDS + 1);

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

  typedef logic [XLEN-1:0]        addr_t;
  typedef logic [FETCH_WORDS-1:0] miss_mask_t;
  typedef logic [WORD_IDX_W-1:0]  word_cnt_t;

  // Redirect targets must be halfword aligned, so bit 0 is always dropped.
  function automatic addr_t align_target(input addr_t target);
    return {target[XLEN-1:1], 1'b0};
  endfunction

  // Decode may report 5..7 words; only a full block can ever be consumed.
  function automatic word_cnt_t clamp_di_count(input logic [2:0] di_count);
    return (di_count > 3'(FETCH_WORDS)) ? word_cnt_t'(FETCH_WORDS) : word_cnt_t'(di_count);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch PC control bus: miss flags, decode consumption, redirects and the PC.
// The master side is the surrounding pipeline; the slave side is the PC controller.
interface fetch_pc_ctrl_if;
  import fetch_pc_ctrl_pkg::*;

  logic [3:0]  i_cache_miss;
  logic [2:0]  i_di_count;
  logic        i_branch_en;
  addr_t       i_branch_target;
  logic        i_flush_en;
  addr_t       i_flush_target;
  addr_t       o_pc;

  modport master (
    output i_cache_miss,
    output i_di_count,
    output i_branch_en,
    output i_branch_target,
    output i_flush_en,
    output i_flush_target,
    input  o_pc
  );

  modport slave (
    input  i_cache_miss,
    input  i_di_count,
    input  i_branch_en,
    input  i_branch_target,
    input  i_flush_en,
    input  i_flush_target,
    output o_pc
  );

endinterface

// File: rtl/fetch_pc_ctrl_first_miss_enc.sv
// Lowest-set-bit encoder over the per-word icache miss flags.
// Output is the index of the first missing word, or FETCH_WORDS if none miss.
module first_miss_enc
  import fetch_pc_ctrl_pkg::*;
(
  input  miss_mask_t miss,
  output word_cnt_t  first_miss
);

  always_comb begin
    // NOTE: assigning a default before the priority chain guarantees every path drives first_miss, so no latch is inferred.
    first_miss = word_cnt_t'(FETCH_WORDS);
    for (int k = FETCH_WORDS - 1; k >= 0; k--) begin
      if (miss[k]) first_miss = word_cnt_t'(k);
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC register with flush/branch redirect and miss-limited sequential advance.
// Next-PC logic is combinational; the PC itself is the only state.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  fetch_pc_ctrl_if.slave         bus
);

  word_cnt_t first_miss;
  word_cnt_t di_clamped;
  word_cnt_t adv_words;
  addr_t     pc_q;
  addr_t     pc_next;

  first_miss_enc u_first_miss_enc (
    .miss       (bus.i_cache_miss),
    .first_miss (first_miss)
  );

  // Words actually delivered: no further than decode consumed, nor past the first miss.
  assign di_clamped = clamp_di_count(bus.i_di_count);
  assign adv_words  = (di_clamped < first_miss) ? di_clamped : first_miss;

  always_comb begin
    pc_next = pc_q + {{(XLEN - WORD_IDX_W - 2){1'b0}}, adv_words, 2'b00};
    if (bus.i_flush_en) begin
      pc_next = align_target(bus.i_flush_target);
    end else if (bus.i_branch_en) begin
      pc_next = align_target(bus.i_branch_target);
    end
  end

  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values regardless of block ordering.
    if (i_rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign bus.o_pc = pc_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed boundary cases plus a random run,
// with expected PCs from an independent word-by-word model queued as a scoreboard.
module tb_fetch_pc_ctrl;
  import fetch_pc_ctrl_pkg::*;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  fetch_pc_ctrl_if bus ();

  fetch_pc_ctrl #(.RESET_VECTOR(RV)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] model_pc;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  // Reference: walk the block one word at a time, stopping at the count or a miss.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic r,
                                             input logic [3:0] miss, input logic [2:0] di,
                                             input logic br, input logic [31:0] bt,
                                             input logic fl, input logic [31:0] ft);
    logic [31:0] p;
    if (r) return RV;
    if (fl) return ft & 32'hFFFF_FFFE;
    if (br) return bt & 32'hFFFF_FFFE;
    p = pc;
    for (int w = 0; w < 4; w++) begin
      if (w >= int'(di) || miss[w]) break;
      p = p + 32'd4;
    end
    return p;
  endfunction

  task automatic apply(input string tag, input logic r, input logic [3:0] miss,
                       input logic [2:0] di, input logic br, input logic [31:0] bt,
                       input logic fl, input logic [31:0] ft);
    @(negedge clk);
    rst                 = r;
    bus.i_cache_miss    = miss;
    bus.i_di_count      = di;
    bus.i_branch_en     = br;
    bus.i_branch_target = bt;
    bus.i_flush_en      = fl;
    bus.i_flush_target  = ft;
    model_pc = model_next(model_pc, r, miss, di, br, bt, fl, ft);
    exp_q.push_back(model_pc);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check(tag_q.pop_front(), bus.o_pc, exp_q.pop_front());
  endtask

  initial begin
    rst                 = 1'b1;
    bus.i_cache_miss    = '0;
    bus.i_di_count      = '0;
    bus.i_branch_en     = 1'b0;
    bus.i_branch_target = '0;
    bus.i_flush_en      = 1'b0;
    bus.i_flush_target  = '0;
    model_pc            = '0;

    // Reset for two cycles, then full-block sequential advance.
    apply("reset0", 1, 4'b0000, 3'd4, 0, 32'h0, 0, 32'h0);
    apply("reset1", 1, 4'b0000, 3'd4, 0, 32'h0, 0, 32'h0);
    apply("seq16a", 0, 4'b0000, 3'd4, 0, 32'h0, 0, 32'h0);
    apply("seq16b", 0, 4'b0000, 3'd4, 0, 32'h0, 0, 32'h0);

    // Miss-limited advance and holds.
    apply("reset2", 1, 4'b0000, 3'd0, 0, 32'h0, 0, 32'h0);
    apply("miss2",  0, 4'b0100, 3'd4, 0, 32'h0, 0, 32'h0);
    apply("miss0h", 0, 4'b0001, 3'd4, 0, 32'h0, 0, 32'h0);
    apply("di0h",   0, 4'b0000, 3'd0, 0, 32'h0, 0, 32'h0);

    // Redirects: bit 0 cleared, flush beats branch.
    apply("branch", 0, 4'b1111, 3'd4, 1, 32'h0000_1235, 0, 32'h0);
    apply("flushbr", 0, 4'b0000, 3'd4, 1, 32'h0000_5000, 1, 32'h0000_2000);
    apply("flushodd", 0, 4'b0000, 3'd2, 0, 32'h0, 1, 32'h0000_3003);

    // Wrap-around.
    apply("br_top", 0, 4'b0000, 3'd0, 1, 32'hFFFF_FFF8, 0, 32'h0);
    apply("wrap",   0, 4'b0000, 3'd4, 0, 32'h0, 0, 32'h0);

    // Clamp of oversized counts and late-miss limiting.
    apply("di7",    0, 4'b0000, 3'd7, 0, 32'h0, 0, 32'h0);
    apply("di5",    0, 4'b0000, 3'd5, 0, 32'h0, 0, 32'h0);
    apply("di3m3",  0, 4'b1000, 3'd3, 0, 32'h0, 0, 32'h0);
    apply("di4m1",  0, 4'b1010, 3'd4, 0, 32'h0, 0, 32'h0);

    // Reset wins over a simultaneous flush and branch.
    apply("rstflush", 1, 4'b0000, 3'd4, 1, 32'h0000_4000, 1, 32'h0000_2000);
    apply("postrst",  0, 4'b0000, 3'd4, 0, 32'h0, 0, 32'h0);

    // Random traffic with occasional redirects and mid-run resets.
    for (int i = 0; i < 60; i++) begin
      logic        r, br, fl;
      logic [3:0]  miss;
      logic [2:0]  di;
      logic [31:0] bt, ft;
      r    = ($urandom_range(0, 19) == 0);
      br   = ($urandom_range(0, 5) == 0);
      fl   = ($urandom_range(0, 7) == 0);
      miss = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) miss = 4'b0000;
      di   = 3'($urandom_range(0, 7));
      bt   = $urandom;
      ft   = $urandom;
      apply($sformatf("rand%0d", i), r, miss, di, br, bt, fl, ft);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
